// File: rtl/mc_pkg.sv
// Shared constants for the multicycle MIPS-style controller: state encodings,
// opcode/funct values, ALU operation codes, mux select codes and the
// per-state control bundle.
// Build option: define ADDI_EN to enable ADDI (states ADDIEX/ADDIWR).
package mc_pkg;

    // State encodings (4-bit, order fixed for the debug port)
    localparam logic [3:0] S_FETCH1  = 4'd0;
    localparam logic [3:0] S_FETCH2  = 4'd1;
    localparam logic [3:0] S_FETCH3  = 4'd2;
    localparam logic [3:0] S_FETCH4  = 4'd3;
    localparam logic [3:0] S_DECODE  = 4'd4;
    localparam logic [3:0] S_MEMADR  = 4'd5;
    localparam logic [3:0] S_LBRD    = 4'd6;
    localparam logic [3:0] S_LBWR    = 4'd7;
    localparam logic [3:0] S_SBWR    = 4'd8;
    localparam logic [3:0] S_RTYPEEX = 4'd9;
    localparam logic [3:0] S_RTYPEWR = 4'd10;
    localparam logic [3:0] S_BEQEX   = 4'd11;
    localparam logic [3:0] S_JEX     = 4'd12;
    localparam logic [3:0] S_ADDIEX  = 4'd13;
    localparam logic [3:0] S_ADDIWR  = 4'd14;

    // Opcodes (instr[31:26])
    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_LB    = 6'b100000;
    localparam logic [5:0] OP_SB    = 6'b101000;

    // R-type function codes (instr[5:0])
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    // aluop: how the ALU decoder should pick the operation
    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // alucontrol values
    localparam logic [2:0] ALU_AND = 3'b000;
    localparam logic [2:0] ALU_OR  = 3'b001;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // ALU B-operand select
    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_ONE   = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_BRIMM = 2'b11;

    // PC source select
    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    // Everything the state decode produces; alu_en marks states that drive
    // the ALU so alucontrol reads 0 everywhere else.
    typedef struct packed {
        logic       memread;
        logic       memwrite;
        logic       alusrca;
        logic [1:0] alusrcb;
        logic       memtoreg;
        logic       regdst;
        logic       iord;
        logic       regwrite;
        logic [1:0] pcsrc;
        logic [3:0] irwrite;
        logic       pcwrite;
        logic       branch;
        logic       alu_en;
        logic [1:0] aluop;
    } ctrl_t;

    localparam ctrl_t CTRL_IDLE = '0;

endpackage

// File: rtl/alu_dec.sv
// ALU operation decoder: aluop plus R-type funct field -> alucontrol.
module alu_dec
    import mc_pkg::*;
(
    input  logic [1:0] aluop,
    input  logic [5:0] funct,
    output logic [2:0] alucontrol
);

    // Fixed add/sub for address and branch math, funct table for R-type
    always_comb begin
        alucontrol = ALU_ADD;
        case (aluop)
            ALUOP_ADD: alucontrol = ALU_ADD;
            ALUOP_SUB: alucontrol = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct)
                    FN_ADD:  alucontrol = ALU_ADD;
                    FN_SUB:  alucontrol = ALU_SUB;
                    FN_AND:  alucontrol = ALU_AND;
                    FN_OR:   alucontrol = ALU_OR;
                    FN_SLT:  alucontrol = ALU_SLT;
                    default: alucontrol = ALU_ADD;
                endcase
            end
            default: alucontrol = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/mcycle_control.sv
// Multicycle controller (Moore FSM) with a byte-wide, four-beat instruction
// fetch. Outputs are decoded from the state register; only pcen also looks at
// the zero flag. Reset forces every output low in the same cycle so a reset
// landing mid-instruction cannot produce a partial write.
// Build option: define ADDI_EN to enable ADDI (ADDIEX -> ADDIWR).
module mcycle_control
    import mc_pkg::*;
(
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] op,
    input  logic [5:0] funct,
    input  logic       zero,
    output logic       memread,
    output logic       memwrite,
    output logic       alusrca,
    output logic [1:0] alusrcb,
    output logic       memtoreg,
    output logic       regdst,
    output logic       iord,
    output logic       pcen,
    output logic       regwrite,
    output logic [1:0] pcsrc,
    output logic [3:0] irwrite,
    output logic [2:0] alucontrol,
    output logic [3:0] state
);

    logic [3:0] state_q;
    logic [3:0] state_d;
    ctrl_t      ctrl;
    logic [2:0] alu_dec_out;

    alu_dec u_alu_dec (
        .aluop      (ctrl.aluop),
        .funct      (funct),
        .alucontrol (alu_dec_out)
    );

    // Next-state logic; unknown or reserved encodings fall back to FETCH1
    always_comb begin
        state_d = S_FETCH1;
        case (state_q)
            S_FETCH1: state_d = S_FETCH2;
            S_FETCH2: state_d = S_FETCH3;
            S_FETCH3: state_d = S_FETCH4;
            S_FETCH4: state_d = S_DECODE;
            S_DECODE: begin
                case (op)
                    OP_LB, OP_SB: state_d = S_MEMADR;
                    OP_RTYPE:     state_d = S_RTYPEEX;
                    OP_BEQ:       state_d = S_BEQEX;
                    OP_J:         state_d = S_JEX;
`ifdef ADDI_EN
                    OP_ADDI:      state_d = S_ADDIEX;
`else
                    OP_ADDI:      state_d = S_FETCH1;  // illegal in this build
`endif
                    default:      state_d = S_FETCH1;
                endcase
            end
            S_MEMADR:  state_d = (op == OP_LB) ? S_LBRD : S_SBWR;
            S_LBRD:    state_d = S_LBWR;
            S_RTYPEEX: state_d = S_RTYPEWR;
`ifdef ADDI_EN
            S_ADDIEX:  state_d = S_ADDIWR;
`endif
            default:   state_d = S_FETCH1;
        endcase
        if (reset) begin
            state_d = S_FETCH1;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_FETCH1;
        end else begin
            state_q <= state_d;
        end
    end

    // Per-state control decode; anything not set stays 0
    always_comb begin
        ctrl = CTRL_IDLE;
        case (state_q)
            S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
                ctrl.memread = 1'b1;
                // FETCH1..4 encode as 0..3, so the low bits pick the byte lane
                ctrl.irwrite = 4'b0001 << state_q[1:0];
                ctrl.alusrcb = SRCB_ONE;
                ctrl.pcsrc   = PCSRC_ALU;
                ctrl.pcwrite = 1'b1;
                ctrl.alu_en  = 1'b1;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_DECODE: begin
                ctrl.alusrcb = SRCB_BRIMM;
                ctrl.alu_en  = 1'b1;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_MEMADR: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.alu_en  = 1'b1;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_LBRD: begin
                ctrl.memread = 1'b1;
                ctrl.iord    = 1'b1;
            end
            S_LBWR: begin
                ctrl.regwrite = 1'b1;
                ctrl.memtoreg = 1'b1;
            end
            S_SBWR: begin
                ctrl.memwrite = 1'b1;
                ctrl.iord     = 1'b1;
            end
            S_RTYPEEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.alu_en  = 1'b1;
                ctrl.aluop   = ALUOP_FUNCT;
            end
            S_RTYPEWR: begin
                ctrl.regwrite = 1'b1;
                ctrl.regdst   = 1'b1;
            end
            S_BEQEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_B;
                ctrl.alu_en  = 1'b1;
                ctrl.aluop   = ALUOP_SUB;
                ctrl.branch  = 1'b1;
                ctrl.pcsrc   = PCSRC_ALUOUT;
            end
            S_JEX: begin
                ctrl.pcwrite = 1'b1;
                ctrl.pcsrc   = PCSRC_JUMP;
            end
`ifdef ADDI_EN
            S_ADDIEX: begin
                ctrl.alusrca = 1'b1;
                ctrl.alusrcb = SRCB_IMM;
                ctrl.alu_en  = 1'b1;
                ctrl.aluop   = ALUOP_ADD;
            end
            S_ADDIWR: begin
                ctrl.regwrite = 1'b1;
            end
`else
            S_ADDIEX, S_ADDIWR: ctrl = CTRL_IDLE;  // reserved, unreachable
`endif
            default: ctrl = CTRL_IDLE;
        endcase
    end

    // Reset masks every output combinationally, including the debug state
    assign memread    = ctrl.memread  & ~reset;
    assign memwrite   = ctrl.memwrite & ~reset;
    assign alusrca    = ctrl.alusrca  & ~reset;
    assign alusrcb    = reset ? 2'b00 : ctrl.alusrcb;
    assign memtoreg   = ctrl.memtoreg & ~reset;
    assign regdst     = ctrl.regdst   & ~reset;
    assign iord       = ctrl.iord     & ~reset;
    assign regwrite   = ctrl.regwrite & ~reset;
    assign pcsrc      = reset ? 2'b00 : ctrl.pcsrc;
    assign irwrite    = reset ? 4'b0000 : ctrl.irwrite;
    assign alucontrol = (reset || !ctrl.alu_en) ? 3'b000 : alu_dec_out;
    assign pcen       = ~reset & (ctrl.pcwrite | (ctrl.branch & zero));
    assign state      = reset ? 4'd0 : state_q;

endmodule

// File: tb/tb_mcycle_control.sv
// Directed bench for mcycle_control: a cycle-by-cycle vector table with
// hand-computed outputs, plus instruction-latency sequences.
module tb_mcycle_control;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       memread, memwrite, alusrca, memtoreg, regdst, iord, pcen, regwrite;
    logic [1:0] alusrcb, pcsrc;
    logic [3:0] irwrite, state;
    logic [2:0] alucontrol;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    mcycle_control dut (
        .clk        (clk),
        .reset      (reset),
        .op         (op),
        .funct      (funct),
        .zero       (zero),
        .memread    (memread),
        .memwrite   (memwrite),
        .alusrca    (alusrca),
        .alusrcb    (alusrcb),
        .memtoreg   (memtoreg),
        .regdst     (regdst),
        .iord       (iord),
        .pcen       (pcen),
        .regwrite   (regwrite),
        .pcsrc      (pcsrc),
        .irwrite    (irwrite),
        .alucontrol (alucontrol),
        .state      (state)
    );

    typedef struct {
        logic       rst;
        logic [5:0] opv;
        logic [5:0] fnv;
        logic       zv;
        logic [3:0] st;
        logic [18:0] outs;
    } vec_t;

    vec_t vecs[$];

    // {memread,memwrite,alusrca,alusrcb,memtoreg,regdst,iord,pcen,regwrite,pcsrc,irwrite,alucontrol}
    function automatic logic [18:0] o(input logic mr, input logic mw, input logic asa,
                                      input logic [1:0] asb, input logic m2r, input logic rd,
                                      input logic io, input logic pe, input logic rw,
                                      input logic [1:0] ps, input logic [3:0] ir,
                                      input logic [2:0] ac);
        return {mr, mw, asa, asb, m2r, rd, io, pe, rw, ps, ir, ac};
    endfunction

    task automatic add(input logic r, input logic [5:0] ov, input logic [5:0] fv,
                       input logic zv, input logic [3:0] st, input logic [18:0] outs);
        vecs.push_back('{rst: r, opv: ov, fnv: fv, zv: zv, st: st, outs: outs});
    endtask

    // FETCH1..FETCH4 then DECODE
    task automatic add_fetch(input logic [5:0] ov, input logic [5:0] fv, input logic zv);
        add(0, ov, fv, zv, 4'd0, o(1,0,0,2'b01,0,0,0,1,0,2'b00,4'b0001,3'b010));
        add(0, ov, fv, zv, 4'd1, o(1,0,0,2'b01,0,0,0,1,0,2'b00,4'b0010,3'b010));
        add(0, ov, fv, zv, 4'd2, o(1,0,0,2'b01,0,0,0,1,0,2'b00,4'b0100,3'b010));
        add(0, ov, fv, zv, 4'd3, o(1,0,0,2'b01,0,0,0,1,0,2'b00,4'b1000,3'b010));
        add(0, ov, fv, zv, 4'd4, o(0,0,0,2'b11,0,0,0,0,0,2'b00,4'b0000,3'b010));
    endtask

    task automatic add_rtype(input logic [5:0] fv, input logic [2:0] ac);
        add_fetch(6'b000000, fv, 0);
        add(0, 6'b000000, fv, 0, 4'd9,  o(0,0,1,2'b00,0,0,0,0,0,2'b00,4'b0000,ac));
        add(0, 6'b000000, fv, 0, 4'd10, o(0,0,0,2'b00,0,1,0,0,1,2'b00,4'b0000,3'b000));
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Run one instruction from FETCH1 back to FETCH1; count cycles and write pulses
    task automatic measure(input logic [5:0] ov, input int exp_cyc, input int exp_wr,
                           input string nm);
        int n;
        int wr;
        op = ov;
        funct = 6'b100000;
        zero = 1'b0;
        n = 0;
        wr = 0;
        do begin
            @(negedge clk);
            n++;
            if (regwrite || memwrite) wr++;
        end while (state != 4'd0 && n < 20);
        chk({nm, "_latency"}, n, exp_cyc);
        chk({nm, "_writes"}, wr, exp_wr);
        $display("seq %s: cycles=%0d writes=%0d", nm, n, wr);
    endtask

    initial begin
        // Reset for two cycles: everything reads 0
        add(1, 6'b100000, 6'b0, 1, 4'd0, 19'd0);
        add(1, 6'b100000, 6'b0, 1, 4'd0, 19'd0);
        // R-type, every funct decode plus an unknown funct
        add_rtype(6'b100010, 3'b110);
        add_rtype(6'b100000, 3'b010);
        add_rtype(6'b100100, 3'b000);
        add_rtype(6'b100101, 3'b001);
        add_rtype(6'b101010, 3'b111);
        add_rtype(6'b111111, 3'b010);
        // LB
        add_fetch(6'b100000, 0, 0);
        add(0, 6'b100000, 0, 0, 4'd5, o(0,0,1,2'b10,0,0,0,0,0,2'b00,4'b0000,3'b010));
        add(0, 6'b100000, 0, 0, 4'd6, o(1,0,0,2'b00,0,0,1,0,0,2'b00,4'b0000,3'b000));
        add(0, 6'b100000, 0, 0, 4'd7, o(0,0,0,2'b00,1,0,0,0,1,2'b00,4'b0000,3'b000));
        // SB
        add_fetch(6'b101000, 0, 0);
        add(0, 6'b101000, 0, 0, 4'd5, o(0,0,1,2'b10,0,0,0,0,0,2'b00,4'b0000,3'b010));
        add(0, 6'b101000, 0, 0, 4'd8, o(0,1,0,2'b00,0,0,1,0,0,2'b00,4'b0000,3'b000));
        // BEQ taken and not taken
        add_fetch(6'b000100, 0, 1);
        add(0, 6'b000100, 0, 1, 4'd11, o(0,0,1,2'b00,0,0,0,1,0,2'b01,4'b0000,3'b110));
        add_fetch(6'b000100, 0, 0);
        add(0, 6'b000100, 0, 0, 4'd11, o(0,0,1,2'b00,0,0,0,0,0,2'b01,4'b0000,3'b110));
        // J
        add_fetch(6'b000010, 0, 0);
        add(0, 6'b000010, 0, 0, 4'd12, o(0,0,0,2'b00,0,0,0,1,0,2'b10,4'b0000,3'b000));
        // Illegal op
        add_fetch(6'b111111, 0, 0);
        // ADDI
        add_fetch(6'b001000, 0, 0);
`ifdef ADDI_EN
        add(0, 6'b001000, 0, 0, 4'd13, o(0,0,1,2'b10,0,0,0,0,0,2'b00,4'b0000,3'b010));
        add(0, 6'b001000, 0, 0, 4'd14, o(0,0,0,2'b00,0,0,0,0,1,2'b00,4'b0000,3'b000));
`endif
        // Reset lands in LBRD: outputs all 0, then FETCH1
        add_fetch(6'b100000, 0, 0);
        add(0, 6'b100000, 0, 0, 4'd5, o(0,0,1,2'b10,0,0,0,0,0,2'b00,4'b0000,3'b010));
        add(1, 6'b100000, 0, 1, 4'd0, 19'd0);
        add(0, 6'b100000, 0, 0, 4'd0, o(1,0,0,2'b01,0,0,0,1,0,2'b00,4'b0001,3'b010));

        foreach (vecs[i]) begin
            reset = vecs[i].rst;
            op    = vecs[i].opv;
            funct = vecs[i].fnv;
            zero  = vecs[i].zv;
            @(negedge clk);
            chk($sformatf("row%0d_state", i), state, vecs[i].st);
            chk($sformatf("row%0d_outs", i),
                {memread, memwrite, alusrca, alusrcb, memtoreg, regdst, iord, pcen,
                 regwrite, pcsrc, irwrite, alucontrol}, vecs[i].outs);
            $display("row %0d: rst=%0b op=%b st=%0d outs=%b", i, vecs[i].rst, vecs[i].opv,
                     state, {memread, memwrite, alusrca, alusrcb, memtoreg, regdst, iord,
                     pcen, regwrite, pcsrc, irwrite, alucontrol});
            @(posedge clk);
            #1;
        end

        // Resynchronise to FETCH1, then time whole instructions
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        chk("resync_state", state, 4'd0);
        measure(6'b100000, 8, 1, "lb");
        measure(6'b101000, 7, 1, "sb");
        measure(6'b000000, 7, 1, "rtype");
        measure(6'b000100, 6, 0, "beq");
        measure(6'b000010, 6, 0, "j");
        measure(6'b111111, 5, 0, "illegal");
`ifdef ADDI_EN
        measure(6'b001000, 7, 1, "addi");
`else
        measure(6'b001000, 5, 0, "addi_off");
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
